// File: rtl/FixedPoint.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | FixedPoint                                                           |
// | Signed fixed-point type, constants, BCE FSM state, saturating math.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package FixedPoint;

  typedef logic signed [15:0] sfp;

  localparam int SFP_W    = $bits(sfp);
  localparam int SFP_FRAC = 8;

  localparam sfp ONE     = 16'sd256;
  localparam sfp HALF    = 16'sd128;
  localparam sfp EPSILON = 16'sd1;

  // Symmetric range so that negating any in-range value never overflows.
  localparam sfp SFP_MAX = 16'sh7FFF;
  localparam sfp SFP_MIN = 16'sh8001;

  localparam logic signed [SFP_W:0] SFP_MAX_X = {1'b0, SFP_MAX};
  localparam logic signed [SFP_W:0] SFP_MIN_X = {1'b1, SFP_MIN};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_A = 2'd1,
    DIV_B = 2'd2,
    DONE  = 2'd3
  } bce_state_t;

  function automatic sfp sat_clip(input logic signed [SFP_W:0] s);
    if (s > SFP_MAX_X) return SFP_MAX;
    else if (s < SFP_MIN_X) return SFP_MIN;
    else return s[SFP_W-1:0];
  endfunction

  function automatic sfp sat_add(input sfp a, input sfp b);
    logic signed [SFP_W:0] s;
    s = {a[SFP_W-1], a} + {b[SFP_W-1], b};
    return sat_clip(s);
  endfunction

  function automatic sfp sat_sub(input sfp a, input sfp b);
    logic signed [SFP_W:0] s;
    s = {a[SFP_W-1], a} - {b[SFP_W-1], b};
    return sat_clip(s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sfp_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sfp_seq_divider                                                      |
// | W-cycle restoring divider num/den in sfp, with denominator clamp     |
// | and saturating quotient. Revision: 1.0                               |
// +----------------------------------------------------------------------+
module sfp_seq_divider
  import FixedPoint::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  sfp   num,
  input  sfp   den,
  output logic done,
  output sfp   quotient
);

  localparam int W  = $bits(sfp);
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] C_EPS_U = EPSILON;

  logic [W-1:0] w_num_u, w_den_u, w_num_mag, w_den_abs, w_den_mag;
  logic [W-1:0] w_hi, w_low;
  logic [W-1:0] w_rem_src, w_shf_src, w_dsr, w_q_src, w_rem_nxt;
  logic [W:0]   w_trial;
  logic         w_fit, w_neg, w_ovf;

  logic [W-1:0]  r_rem, r_shf, r_den, r_q;
  logic [CW-1:0] r_cnt;
  logic          r_active, r_done, r_neg, r_ovf;

  assign w_num_u   = num;
  assign w_den_u   = den;
  assign w_num_mag = w_num_u[W-1] ? (~w_num_u + 1'b1) : w_num_u;
  assign w_den_abs = w_den_u[W-1] ? (~w_den_u + 1'b1) : w_den_u;
  assign w_den_mag = (w_den_abs < C_EPS_U) ? C_EPS_U : w_den_abs;
  assign w_neg     = w_num_u[W-1] ^ w_den_u[W-1];

  // Dividend is mag<<FRAC; if its upper W bits already reach the divisor
  // the quotient needs more than W bits, so overflow is known up front.
  assign w_hi  = w_num_mag >> (W - SFP_FRAC);
  assign w_low = w_num_mag << SFP_FRAC;
  assign w_ovf = (w_hi >= w_den_mag);

  // The start cycle performs the first iteration straight from the operands.
  assign w_rem_src = start ? w_hi      : r_rem;
  assign w_shf_src = start ? w_low     : r_shf;
  assign w_dsr     = start ? w_den_mag : r_den;
  assign w_q_src   = start ? '0        : r_q;

  assign w_trial   = {w_rem_src, w_shf_src[W-1]};
  assign w_fit     = (w_trial >= {1'b0, w_dsr});
  assign w_rem_nxt = W'(w_fit ? (w_trial - {1'b0, w_dsr}) : w_trial);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_shf    <= '0;
      r_den    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (start) begin
        r_active <= 1'b1;
        r_cnt    <= CW'(W - 1);
        r_done   <= 1'b0;
        r_neg    <= w_neg;
        r_ovf    <= w_ovf;
        r_den    <= w_den_mag;
      end else if (r_active) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end else begin
        r_done <= 1'b0;
      end
      if (start || r_active) begin
        r_rem <= w_rem_nxt;
        r_shf <= W'({w_shf_src, 1'b0});
        r_q   <= W'({w_q_src, w_fit});
      end
    end
  end

  assign done = r_done;

  always_comb begin
    if (r_ovf || r_q[W-1]) quotient = r_neg ? SFP_MIN : SFP_MAX;
    else if (r_neg)        quotient = -$signed(r_q);
    else                   quotient = $signed(r_q);
  end

endmodule
`default_nettype wire

// File: rtl/bce_gradient_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bce_gradient_unit                                                    |
// | BCE gradient (1-y)/(1-p-eps) - y/(p+eps) using one shared divider.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bce_gradient_unit
  import FixedPoint::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  sfp   prediction,
  input  sfp   expected,
  output logic out_valid,
  input  logic out_ready,
  output sfp   error_gradient,
  output logic busy
);

  bce_state_t r_state, w_state_nxt;
  sfp         r_p, r_y, r_qa, r_grad;
  sfp         w_div_num, w_div_den, w_div_q;
  logic       w_accept, w_div_start, w_div_done;

  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  // qA starts on the accepting edge from the live inputs; qB starts the
  // moment qA completes, from the registered operands.
  always_comb begin
    w_state_nxt = r_state;
    w_div_start = 1'b0;
    w_div_num   = expected;
    w_div_den   = sat_add(prediction, EPSILON);
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = DIV_A;
          w_div_start = 1'b1;
        end
      end
      DIV_A: begin
        if (w_div_done) begin
          w_state_nxt = DIV_B;
          w_div_start = 1'b1;
          w_div_num   = sat_sub(ONE, r_y);
          w_div_den   = sat_sub(ONE, sat_add(r_p, EPSILON));
        end
      end
      DIV_B: begin
        if (w_div_done) w_state_nxt = DONE;
      end
      DONE: begin
        if (w_accept) begin
          w_state_nxt = DIV_A;
          w_div_start = 1'b1;
        end else if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_p     <= '0;
      r_y     <= '0;
      r_qa    <= '0;
      r_grad  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_p <= prediction;
        r_y <= expected;
      end
      if ((r_state == DIV_A) && w_div_done) r_qa <= w_div_q;
      if ((r_state == DIV_B) && w_div_done) r_grad <= sat_sub(w_div_q, r_qa);
    end
  end

  sfp_seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_div_start),
    .num      (w_div_num),
    .den      (w_div_den),
    .done     (w_div_done),
    .quotient (w_div_q)
  );

  assign out_valid      = (r_state == DONE);
  assign busy           = (r_state == DIV_A) || (r_state == DIV_B);
  assign error_gradient = r_grad;

endmodule
`default_nettype wire

// File: tb/tb_bce_gradient_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bce_gradient_unit                                                 |
// | Directed self-checking bench for bce_gradient_unit (ONE=256, eps=1). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bce_gradient_unit;

  localparam int W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] prediction;
  logic signed [15:0] expected;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] error_gradient;
  logic               busy;

  int checks = 0;
  int errors = 0;

  bce_gradient_unit dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .prediction     (prediction),
    .expected       (expected),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .error_gradient (error_gradient),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offers one sample, returns the cycle (counted from the transfer cycle)
  // in which out_valid is first seen high.
  task automatic run_sample(input int p, input int y, output int lat);
    int n;
    prediction = 16'(p);
    expected   = 16'(y);
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("in_ready_while_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    lat = lat + 1;
  endtask

  int p_s[4]   = '{64, 32, 192, 224};
  int y_s[4]   = '{0, 0, 0, 256};
  int exp_s[4] = '{343, 293, 1040, -291};

  initial begin
    int lat, seen, idx_in, idx_out, cyc, last;
    logic acc;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    prediction = 16'sd128; expected = 16'sd256;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_grad", error_gradient, 0);
    chk("reset_in_ready", in_ready, 1);

    // p=HALF, y=ONE: -256/(129/256) -> -508; held with out_ready low.
    run_sample(128, 256, lat);
    chk("latency_half_one", lat, 2*W+1);
    chk("grad_half_one", error_gradient, -508);
    prediction = 16'sd0; expected = 16'sd256; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_grad", error_gradient, -508);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_busy", busy, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);

    // p=HALF, y=0: 256/(127/256) -> 516.
    run_sample(128, 0, lat);
    chk("latency_half_zero", lat, 2*W+1);
    chk("grad_half_zero", error_gradient, 516);
    tick();
    chk("drop_after_take", out_valid, 0);

    // p=0, y=ONE: qA overflows -> gradient saturates to the minimum.
    run_sample(0, 256, lat);
    chk("grad_sat_min", error_gradient, -32767);
    tick();

    // Reset in the middle of DIV_A aborts the division.
    prediction = 16'sd128; expected = 16'sd256; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W/2 - 1; i++) tick();
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    run_sample(128, 256, lat);
    chk("after_abort_latency", lat, 2*W+1);
    chk("after_abort_grad", error_gradient, -508);
    tick();

    // Four AND-gate samples streamed back-to-back.
    idx_in = 0; idx_out = 0; cyc = 0; last = 0;
    while (idx_out < 4 && cyc < 400) begin
      if (out_valid) begin
        chk($sformatf("stream_grad%0d", idx_out), error_gradient, exp_s[idx_out]);
        if (idx_out > 0) chk("stream_spacing", cyc - last, 2*W+1);
        last = cyc;
        idx_out++;
      end
      if (idx_in < 4) begin
        in_valid   = 1'b1;
        prediction = 16'(p_s[idx_in]);
        expected   = 16'(y_s[idx_in]);
        acc        = in_ready;
      end else begin
        in_valid = 1'b0;
        acc      = 1'b0;
      end
      tick();
      cyc++;
      if (acc) idx_in++;
    end
    chk("stream_count", idx_out, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
